// File: rtl/exec_wb_queue_if.sv
// Handshake bundle for the execution/writeback queue: the integer request port,
// the non-stallable FPU completion port and the GPR writeback port.
interface exec_wb_queue_if #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int FLAG_W = 5
) ();
  logic              int_valid;
  logic [1:0]        int_op;
  logic [XLEN-1:0]   int_rs1;
  logic [XLEN-1:0]   int_rs2;
  logic [TAG_W-1:0]  int_rd;
  logic              int_ready;

  logic              fpu_valid;
  logic [XLEN-1:0]   fpu_result;
  logic [FLAG_W-1:0] fpu_flags;
  logic [TAG_W-1:0]  fpu_rd;

  logic              wb_valid;
  logic              wb_ready;
  logic [XLEN-1:0]   wb_data;
  logic [TAG_W-1:0]  wb_rd;
  logic              wb_src;

  // Producer side: issues integer ops, FPU completions and accepts writebacks.
  modport master (
    output int_valid, int_op, int_rs1, int_rs2, int_rd,
    input  int_ready,
    output fpu_valid, fpu_result, fpu_flags, fpu_rd,
    input  wb_valid, wb_data, wb_rd, wb_src,
    output wb_ready
  );

  // Queue side.
  modport slave (
    input  int_valid, int_op, int_rs1, int_rs2, int_rd,
    output int_ready,
    input  fpu_valid, fpu_result, fpu_flags, fpu_rd,
    output wb_valid, wb_data, wb_rd, wb_src,
    input  wb_ready
  );
endinterface

// File: rtl/exec_wb_queue.sv
// Execution/writeback stage: integer ADDI/LI/SUB results and FPU integer-destination
// completions are merged into one ordered queue drained to the GPR write port.
module exec_wb_queue #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int FLAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  exec_wb_queue_if.slave             bus,
  input  logic                       flags_clr,
  output logic                       activation,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [FLAG_W-1:0]          flags_acc,
  output logic                       overflow_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  // Two's-complement add/subtract; carry and borrow fall off the top bit.
  function automatic logic [XLEN-1:0] alu_result(input logic [1:0] op,
                                                 input logic signed [XLEN-1:0] a,
                                                 input logic signed [XLEN-1:0] b);
    logic signed [XLEN-1:0] r;
    r = (op == 2'b11) ? (a - b) : (a + b);
    return r;
  endfunction

  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [TAG_W-1:0]  rd_mem   [DEPTH];
  logic              src_mem  [DEPTH];

  logic [PW-1:0]     head, tail, int_slot;
  logic [CW-1:0]     free;
  logic              int_is_push, int_room, int_acc, int_push;
  logic              fpu_push, pop, act_p1;
  logic [XLEN-1:0]   int_data;

  // Room is judged before this cycle's pop, so a simultaneous drain never helps
  // an integer op; only the unstallable FPU source may use the slot a pop frees.
  assign free        = CW'(DEPTH) - count;
  assign int_is_push = (bus.int_op != 2'b10);
  assign int_room    = (free >= CW'(2)) | ((free == CW'(1)) & ~bus.fpu_valid);
  assign bus.int_ready = int_is_push ? int_room : 1'b1;
  assign int_acc     = bus.int_valid & bus.int_ready;
  assign int_push    = int_acc & int_is_push;
  assign pop         = bus.wb_valid & bus.wb_ready;
  assign fpu_push    = bus.fpu_valid & ((free != '0) | pop);
  assign int_data    = alu_result(bus.int_op, bus.int_rs1, bus.int_rs2);
  // The FPU entry takes the tail slot first when both sources push together.
  assign int_slot    = fpu_push ? (tail + PW'(1)) : tail;

  assign bus.wb_valid = (count != '0);
  assign bus.wb_data  = bus.wb_valid ? data_mem[head] : '0;
  assign bus.wb_rd    = bus.wb_valid ? rd_mem[head]   : '0;
  assign bus.wb_src   = bus.wb_valid ? src_mem[head]  : 1'b0;
  assign activation   = act_p1;

  // Control state: pointers, occupancy, activation pulse, sticky flags and error.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      act_p1       <= 1'b0;
      flags_acc    <= '0;
      overflow_err <= 1'b0;
    end else begin
      head   <= head + PW'(pop);
      tail   <= tail + PW'(fpu_push) + PW'(int_push);
      count  <= count + CW'(fpu_push) + CW'(int_push) - CW'(pop);
      act_p1 <= int_acc;
      if (fpu_push)
        flags_acc <= (flags_clr ? '0 : flags_acc) | bus.fpu_flags;
      else if (flags_clr)
        flags_acc <= '0;
      if (bus.fpu_valid & ~fpu_push)
        overflow_err <= 1'b1;
    end
  end

  // Queue storage: payload only, validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (fpu_push) begin
      data_mem[tail] <= bus.fpu_result;
      rd_mem[tail]   <= bus.fpu_rd;
      src_mem[tail]  <= 1'b1;
    end
    if (int_push) begin
      data_mem[int_slot] <= int_data;
      rd_mem[int_slot]   <= bus.int_rd;
      src_mem[int_slot]  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_wb_queue.sv
// Directed bench for exec_wb_queue (DEPTH=4): arithmetic, merge order, backpressure,
// FPU overflow, flag accumulation, output hold and mid-stream reset.
module tb_exec_wb_queue;
  logic       clk;
  logic       rst;
  logic       flags_clr;
  logic       activation;
  logic [2:0] count;
  logic [4:0] flags_acc;
  logic       overflow_err;
  int         n_total = 0;
  int         n_bad   = 0;

  exec_wb_queue_if #(.XLEN(32), .TAG_W(5), .FLAG_W(5)) bus ();

  exec_wb_queue #(.XLEN(32), .DEPTH(4), .TAG_W(5), .FLAG_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .flags_clr    (flags_clr),
    .activation   (activation),
    .count        (count),
    .flags_acc    (flags_acc),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_int(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    bus.int_valid = v; bus.int_op = op; bus.int_rs1 = a; bus.int_rs2 = b; bus.int_rd = rd;
  endtask

  task automatic set_fpu(input logic v, input logic [31:0] r, input logic [4:0] f,
                         input logic [4:0] rd);
    bus.fpu_valid = v; bus.fpu_result = r; bus.fpu_flags = f; bus.fpu_rd = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_total++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got=%0h want=0", bus.wb_valid); end
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
    n_total++; if (activation !== 1'b0) begin n_bad++; $display("FAIL reset_activation got=%0h want=0", activation); end
    n_total++; if (flags_acc !== 5'd0) begin n_bad++; $display("FAIL reset_flags got=%b want=00000", flags_acc); end
    n_total++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%0h want=0", overflow_err); end
    n_total++; if (bus.wb_data !== 32'd0) begin n_bad++; $display("FAIL reset_wb_data got=%h want=0", bus.wb_data); end
  endtask

  task automatic test_addi();
    bus.wb_ready = 1'b1;
    set_int(1'b1, 2'b00, 32'd5, 32'd7, 5'd3);
    #1;
    n_total++; if (bus.int_ready !== 1'b1) begin n_bad++; $display("FAIL addi_ready got=%0h want=1", bus.int_ready); end
    tick();
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    #1;
    n_total++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL addi_wb_valid got=%0h want=1", bus.wb_valid); end
    n_total++; if (bus.wb_data !== 32'd12) begin n_bad++; $display("FAIL addi_wb_data got=%h want=0000000c", bus.wb_data); end
    n_total++; if (bus.wb_rd !== 5'd3) begin n_bad++; $display("FAIL addi_wb_rd got=%0d want=3", bus.wb_rd); end
    n_total++; if (bus.wb_src !== 1'b0) begin n_bad++; $display("FAIL addi_wb_src got=%0h want=0", bus.wb_src); end
    n_total++; if (activation !== 1'b1) begin n_bad++; $display("FAIL addi_activation got=%0h want=1", activation); end
    n_total++; if (count !== 3'd1) begin n_bad++; $display("FAIL addi_count1 got=%0d want=1", count); end
    tick();
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL addi_count0 got=%0d want=0", count); end
    n_total++; if (activation !== 1'b0) begin n_bad++; $display("FAIL addi_act_drop got=%0h want=0", activation); end
  endtask

  task automatic test_wrap();
    bus.wb_ready = 1'b1;
    set_int(1'b1, 2'b11, 32'd0, 32'd1, 5'd10);
    tick();
    set_int(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd2, 5'd11);
    #1;
    n_total++; if (bus.wb_data !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sub_borrow got=%h want=ffffffff", bus.wb_data); end
    n_total++; if (bus.wb_rd !== 5'd10) begin n_bad++; $display("FAIL sub_rd got=%0d want=10", bus.wb_rd); end
    tick();
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    #1;
    n_total++; if (bus.wb_data !== 32'd1) begin n_bad++; $display("FAIL addi_wrap got=%h want=00000001", bus.wb_data); end
    n_total++; if (count !== 3'd1) begin n_bad++; $display("FAIL wrap_count got=%0d want=1", count); end
    tick();
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL wrap_drain got=%0d want=0", count); end
  endtask

  task automatic test_dual();
    bus.wb_ready = 1'b0;
    set_fpu(1'b1, 32'hA, 5'd0, 5'd1);
    set_int(1'b1, 2'b01, 32'd0, 32'd9, 5'd2);
    #1;
    n_total++; if (bus.int_ready !== 1'b1) begin n_bad++; $display("FAIL dual_ready got=%0h want=1", bus.int_ready); end
    tick();
    set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    #1;
    n_total++; if (count !== 3'd2) begin n_bad++; $display("FAIL dual_count got=%0d want=2", count); end
    n_total++; if (bus.wb_data !== 32'hA) begin n_bad++; $display("FAIL dual_first_data got=%h want=0000000a", bus.wb_data); end
    n_total++; if (bus.wb_src !== 1'b1) begin n_bad++; $display("FAIL dual_first_src got=%0h want=1", bus.wb_src); end
    n_total++; if (bus.wb_rd !== 5'd1) begin n_bad++; $display("FAIL dual_first_rd got=%0d want=1", bus.wb_rd); end
    bus.wb_ready = 1'b1;
    tick();
    n_total++; if (bus.wb_data !== 32'd9) begin n_bad++; $display("FAIL dual_second_data got=%h want=00000009", bus.wb_data); end
    n_total++; if (bus.wb_src !== 1'b0) begin n_bad++; $display("FAIL dual_second_src got=%0h want=0", bus.wb_src); end
    n_total++; if (bus.wb_rd !== 5'd2) begin n_bad++; $display("FAIL dual_second_rd got=%0d want=2", bus.wb_rd); end
    tick();
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL dual_drain got=%0d want=0", count); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_data [5];
    logic        exp_src  [5];
    exp_data[0] = 32'd10; exp_data[1] = 32'd11; exp_data[2] = 32'd12;
    exp_data[3] = 32'h44; exp_data[4] = 32'h66;
    exp_src[0] = 1'b0; exp_src[1] = 1'b0; exp_src[2] = 1'b0; exp_src[3] = 1'b1; exp_src[4] = 1'b1;
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_int(1'b1, 2'b00, 32'(10 + i), 32'd0, 5'(6 + i));
      tick();
    end
    // One slot left: an arriving FPU result blocks the integer op.
    set_int(1'b1, 2'b00, 32'd1, 32'd1, 5'd20);
    set_fpu(1'b1, 32'h44, 5'b00010, 5'd9);
    #1;
    n_total++; if (bus.int_ready !== 1'b0) begin n_bad++; $display("FAIL fill_int_blocked got=%0h want=0", bus.int_ready); end
    tick();
    set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    n_total++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count got=%0d want=4", count); end
    n_total++; if (activation !== 1'b0) begin n_bad++; $display("FAIL fill_no_act got=%0h want=0", activation); end
    n_total++; if (flags_acc !== 5'b00010) begin n_bad++; $display("FAIL fill_flags got=%b want=00010", flags_acc); end
    n_total++; if (bus.int_ready !== 1'b0) begin n_bad++; $display("FAIL full_int_ready got=%0h want=0", bus.int_ready); end
    set_int(1'b1, 2'b10, 32'd0, 32'd0, 5'd0);
    #1;
    n_total++; if (bus.int_ready !== 1'b1) begin n_bad++; $display("FAIL full_op10_ready got=%0h want=1", bus.int_ready); end
    tick();
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    set_fpu(1'b1, 32'h55, 5'b01000, 5'd12);
    #1;
    n_total++; if (activation !== 1'b1) begin n_bad++; $display("FAIL op10_activation got=%0h want=1", activation); end
    n_total++; if (count !== 3'd4) begin n_bad++; $display("FAIL op10_count got=%0d want=4", count); end
    tick();
    set_fpu(1'b1, 32'h66, 5'b00000, 5'd13);
    bus.wb_ready = 1'b1;
    #1;
    n_total++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%0h want=1", overflow_err); end
    n_total++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got=%0d want=4", count); end
    n_total++; if (flags_acc !== 5'b00010) begin n_bad++; $display("FAIL ovf_flags got=%b want=00010", flags_acc); end
    // Full queue with a pop: the FPU result is taken, occupancy unchanged.
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.wb_data !== exp_data[i] || bus.wb_src !== exp_src[i]) begin
        n_bad++; $display("FAIL drain_order_%0d got=%h/%0h want=%h/%0h", i, bus.wb_data, bus.wb_src, exp_data[i], exp_src[i]);
      end
      tick();
      set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
      if (i == 0) begin
        n_total++; if (count !== 3'd4) begin n_bad++; $display("FAIL pop_push_count got=%0d want=4", count); end
      end
    end
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL ovf_drain got=%0d want=0", count); end
    n_total++; if (overflow_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%0h want=1", overflow_err); end
  endtask

  task automatic test_flags();
    bus.wb_ready = 1'b1;
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    n_total++; if (flags_acc !== 5'b00000) begin n_bad++; $display("FAIL flags_clr0 got=%b want=00000", flags_acc); end
    set_fpu(1'b1, 32'd1, 5'b00001, 5'd1);
    tick();
    n_total++; if (flags_acc !== 5'b00001) begin n_bad++; $display("FAIL flags_first got=%b want=00001", flags_acc); end
    set_fpu(1'b1, 32'd2, 5'b10000, 5'd1);
    tick();
    set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
    n_total++; if (flags_acc !== 5'b10001) begin n_bad++; $display("FAIL flags_or got=%b want=10001", flags_acc); end
    flags_clr = 1'b1;
    tick();
    n_total++; if (flags_acc !== 5'b00000) begin n_bad++; $display("FAIL flags_clr got=%b want=00000", flags_acc); end
    set_fpu(1'b1, 32'd3, 5'b00100, 5'd1);
    tick();
    flags_clr = 1'b0;
    set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
    n_total++; if (flags_acc !== 5'b00100) begin n_bad++; $display("FAIL flags_clr_push got=%b want=00100", flags_acc); end
    tick();
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL flags_drain got=%0d want=0", count); end
  endtask

  task automatic test_hold_reset();
    bus.wb_ready = 1'b0;
    set_int(1'b1, 2'b00, 32'd1, 32'd1, 5'd4);
    tick();
    set_int(1'b1, 2'b00, 32'd2, 32'd2, 5'd5);
    tick();
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd2 || bus.wb_rd !== 5'd4 || bus.wb_src !== 1'b0) begin
        n_bad++; $display("FAIL hold_%0d got=%0h/%h/%0d want=1/00000002/4", i, bus.wb_valid, bus.wb_data, bus.wb_rd);
      end
      n_total++; if (count !== 3'd2) begin n_bad++; $display("FAIL hold_count_%0d got=%0d want=2", i, count); end
      tick();
    end
    // Reset with live inputs: they must be ignored.
    rst = 1'b1;
    set_int(1'b1, 2'b00, 32'd7, 32'd7, 5'd6);
    set_fpu(1'b1, 32'h77, 5'b11111, 5'd7);
    tick();
    rst = 1'b0;
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
    #1;
    n_total++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid got=%0h want=0", bus.wb_valid); end
    n_total++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d want=0", count); end
    n_total++; if (overflow_err !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got=%0h want=0", overflow_err); end
    n_total++; if (activation !== 1'b0) begin n_bad++; $display("FAIL rst_activation got=%0h want=0", activation); end
    n_total++; if (flags_acc !== 5'd0) begin n_bad++; $display("FAIL rst_flags got=%b want=00000", flags_acc); end
  endtask

  initial begin
    rst = 1'b1;
    flags_clr = 1'b0;
    bus.wb_ready = 1'b0;
    set_int(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    set_fpu(1'b0, 32'd0, 5'd0, 5'd0);
    test_reset();
    test_addi();
    test_wrap();
    test_dual();
    test_overflow();
    test_flags();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
